irq_sequencer: RTL and testbench



---
 rtl/irq_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_irq_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer
// Interrupt/exception sequencer for the single-cycle RISC-V core.
// It latches rising edges on three external request lines and holds the
// per-source enable mask (MIE). It takes ecall or the highest-priority
// enabled request at an instruction boundary. On a take it redirects the PC
// to the handler vector and saves the return address. On uret it returns to
// the saved address.
//
// Optional build macro: IRQ_NEST_EN
//   Adds a 3-entry {EPC, CAUSE} stack. A higher-priority interrupt may then
//   preempt a lower-priority handler. ecall handlers are never preempted.
//
// Ports:
//   CLK          system clock, all state updates on rising edge
//   RST          synchronous, active-high reset
//   IRQ[2:0]     external request lines, rising edge = request, IRQ[0] highest
//   STALL        current instruction does not retire this cycle
//   PC_NEXT      sequential next PC of the current instruction
//   ECALL/URET   decoded ecall / uret strobes
//   CSRRSI/CSRRCI decoded set/clear-immediate CSR strobes
//   ZIMM[4:0]    CSR zimm field, bits [2:0] address the MIE bits
//   PC_REDIRECT  PC mux override (combinational)
//   PC_TARGET    redirect address, equals PC_NEXT when not redirecting
//   EPC          saved return address
//   MIE          per-source enable mask
//   PEND         pending request bits
//   CAUSE        active cause: 0 = ecall, 1..3 = IRQ0..IRQ2
//   IN_SERVICE   high while a handler is running
module irq_sequencer #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] VEC_BASE  = 32'h0000_1000,
  parameter int unsigned     VEC_SHIFT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2:0]      IRQ,
  input  logic            STALL,
  input  logic [PC_W-1:0] PC_NEXT,
  input  logic            ECALL,
  input  logic            URET,
  input  logic            CSRRSI,
  input  logic            CSRRCI,
  input  logic [4:0]      ZIMM,
  output logic            PC_REDIRECT,
  output logic [PC_W-1:0] PC_TARGET,
  output logic [PC_W-1:0] EPC,
  output logic [2:0]      MIE,
  output logic [2:0]      PEND,
  output logic [1:0]      CAUSE,
  output logic            IN_SERVICE
);

  typedef enum logic {
    ST_RUN,
    ST_SERVICE
  } state_t;

  state_t          state_q;
  logic [2:0]      irq_d;
  logic [2:0]      pend_q;
  logic [2:0]      mie_q;
  logic [PC_W-1:0] epc_q;
  logic [1:0]      cause_q;

  logic [2:0]      edge_v;
  logic [2:0]      elig;
  logic [1:0]      win_cause;
  logic            take;
  logic            ret;
  logic [1:0]      take_cause;
  logic [2:0]      pend_clr;
  logic [2:0]      pend_n;
  logic [2:0]      mie_n;
  logic            redirect;
  logic [PC_W-1:0] target;

`ifdef IRQ_NEST_EN
  logic [PC_W-1:0] stk_epc [3];
  logic [1:0]      stk_cause [3];
  logic [1:0]      sp_q;
  logic [1:0]      sp_m1;
  logic            push;

  assign sp_m1 = sp_q - 2'd1;
`endif

  always_comb begin
    edge_v = IRQ & ~irq_d;
    elig   = pend_q & mie_q;

    // Scan from the lowest priority upward so the lowest index set wins.
    win_cause = 2'd0;
    for (int unsigned i = 3; i > 0; i--) begin
      if (elig[i-1]) begin
        win_cause = 2'(i);
      end
    end

    take       = 1'b0;
    ret        = 1'b0;
    take_cause = 2'd0;
`ifdef IRQ_NEST_EN
    push       = 1'b0;
`endif

    if (!RST && !STALL) begin
      case (state_q)
        ST_RUN: begin
          if (ECALL) begin
            take       = 1'b1;
            take_cause = 2'd0;
          end else if (elig != 3'b000) begin
            take       = 1'b1;
            take_cause = win_cause;
          end
        end
        ST_SERVICE: begin
          if (URET) begin
            ret = 1'b1;
`ifdef IRQ_NEST_EN
          // cause_q == 0 (ecall) can never be beaten since win_cause >= 1.
          end else if (elig != 3'b000 && win_cause < cause_q && sp_q != 2'd3) begin
            take       = 1'b1;
            push       = 1'b1;
            take_cause = win_cause;
`endif
          end
        end
        default: ;
      endcase
    end

    redirect = 1'b0;
    target   = PC_NEXT;
    if (take) begin
      redirect = 1'b1;
      target   = VEC_BASE + (PC_W'(take_cause) << VEC_SHIFT);
    end else if (ret) begin
      redirect = 1'b1;
      target   = epc_q;
    end

    // A new edge on the bit being serviced re-arms it (set beats clear).
    for (int unsigned i = 0; i < 3; i++) begin
      pend_clr[i] = take && (take_cause == 2'(i + 1));
    end
    pend_n = (pend_q & ~pend_clr) | edge_v;

    // Clear is applied after set so a simultaneous set/clear clears.
    mie_n = mie_q;
    if (!STALL) begin
      mie_n = (mie_q | (CSRRSI ? ZIMM[2:0] : 3'b000)) & ~(CSRRCI ? ZIMM[2:0] : 3'b000);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      irq_d   <= '0;
      pend_q  <= '0;
      mie_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
`ifdef IRQ_NEST_EN
      sp_q    <= '0;
`endif
    end else begin
      irq_d  <= IRQ;
      pend_q <= pend_n;
      mie_q  <= mie_n;
      if (take) begin
        epc_q   <= PC_NEXT;
        cause_q <= take_cause;
        state_q <= ST_SERVICE;
`ifdef IRQ_NEST_EN
        if (push) begin
          stk_epc[sp_q]   <= epc_q;
          stk_cause[sp_q] <= cause_q;
          sp_q            <= sp_q + 2'd1;
        end
`endif
      end else if (ret) begin
`ifdef IRQ_NEST_EN
        if (sp_q != 2'd0) begin
          epc_q   <= stk_epc[sp_m1];
          cause_q <= stk_cause[sp_m1];
          sp_q    <= sp_m1;
        end else begin
          state_q <= ST_RUN;
        end
`else
        state_q <= ST_RUN;
`endif
      end
    end
  end

  assign PC_REDIRECT = redirect;
  assign PC_TARGET   = target;
  assign EPC         = epc_q;
  assign MIE         = mie_q;
  assign PEND        = pend_q;
  assign CAUSE       = cause_q;
  assign IN_SERVICE  = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed, table-driven bench for irq_sequencer.
// Each record holds one cycle of inputs, the expected combinational outputs
// for that cycle, and the expected registered outputs after the clock edge.
module tb_irq_sequencer;

  logic        CLK;
  logic        RST;
  logic [2:0]  IRQ;
  logic        STALL;
  logic [31:0] PC_NEXT;
  logic        ECALL;
  logic        URET;
  logic        CSRRSI;
  logic        CSRRCI;
  logic [4:0]  ZIMM;
  logic        PC_REDIRECT;
  logic [31:0] PC_TARGET;
  logic [31:0] EPC;
  logic [2:0]  MIE;
  logic [2:0]  PEND;
  logic [1:0]  CAUSE;
  logic        IN_SERVICE;

  int total;
  int bad;

  irq_sequencer #(
    .PC_W(32),
    .VEC_BASE(32'h0000_1000),
    .VEC_SHIFT(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .IRQ(IRQ),
    .STALL(STALL),
    .PC_NEXT(PC_NEXT),
    .ECALL(ECALL),
    .URET(URET),
    .CSRRSI(CSRRSI),
    .CSRRCI(CSRRCI),
    .ZIMM(ZIMM),
    .PC_REDIRECT(PC_REDIRECT),
    .PC_TARGET(PC_TARGET),
    .EPC(EPC),
    .MIE(MIE),
    .PEND(PEND),
    .CAUSE(CAUSE),
    .IN_SERVICE(IN_SERVICE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic [2:0]  irq;
    logic        stall;
    logic [31:0] pc;
    logic        ecall;
    logic        uret;
    logic        si;
    logic        ci;
    logic [4:0]  zimm;
    logic        x_redir;
    logic [31:0] x_tgt;
    logic [31:0] x_epc;
    logic [2:0]  x_mie;
    logic [2:0]  x_pend;
    logic [1:0]  x_cause;
    logic        x_svc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs before the rising
  // edge, then check registered outputs just after it.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge CLK);
    RST     = v.rst;
    IRQ     = v.irq;
    STALL   = v.stall;
    PC_NEXT = v.pc;
    ECALL   = v.ecall;
    URET    = v.uret;
    CSRRSI  = v.si;
    CSRRCI  = v.ci;
    ZIMM    = v.zimm;
    #1;
    chk("redirect", idx, 32'(PC_REDIRECT), 32'(v.x_redir));
    chk("target", idx, PC_TARGET, v.x_tgt);
    @(posedge CLK);
    #1;
    chk("epc", idx, EPC, v.x_epc);
    chk("mie", idx, 32'(MIE), 32'(v.x_mie));
    chk("pend", idx, 32'(PEND), 32'(v.x_pend));
    chk("cause", idx, 32'(CAUSE), 32'(v.x_cause));
    chk("in_service", idx, 32'(IN_SERVICE), 32'(v.x_svc));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    total   = 0;
    bad     = 0;
    RST     = 1'b1;
    IRQ     = 3'b000;
    STALL   = 1'b0;
    PC_NEXT = 32'h0;
    ECALL   = 1'b0;
    URET    = 1'b0;
    CSRRSI  = 1'b0;
    CSRRCI  = 1'b0;
    ZIMM    = 5'd0;

    //                rst   irq     stall pc          ecall uret  si    ci    zimm   | redir tgt         epc         mie     pend    cause svc
    tbl.push_back('{1'b1, 3'b000, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h100,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h100,  32'h0,   3'b000, 3'b010, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  1'b0, 32'h100,  32'h0,   3'b010, 3'b010, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1020, 32'h104, 3'b010, 3'b000, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h108, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h104,  32'h104, 3'b010, 3'b000, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h10c, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h10c,  32'h104, 3'b010, 3'b000, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 1'b0, 32'h110, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 32'h110,  32'h104, 3'b111, 3'b101, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 1'b0, 32'h114, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1010, 32'h114, 3'b111, 3'b100, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h118, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h114,  32'h114, 3'b111, 3'b100, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h120, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1030, 32'h120, 3'b111, 3'b000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h124, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h120,  32'h120, 3'b111, 3'b000, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h130, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h130,  32'h120, 3'b111, 3'b001, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1000, 32'h200, 3'b111, 3'b001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h204,  32'h200, 3'b111, 3'b001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h208, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h200,  32'h200, 3'b111, 3'b001, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h300,  32'h200, 3'b111, 3'b001, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h300,  32'h200, 3'b111, 3'b001, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h300,  32'h200, 3'b111, 3'b001, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1010, 32'h300, 3'b111, 3'b000, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h304,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 32'h308,  32'h0,   3'b111, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h308, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 32'h308,  32'h0,   3'b100, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 32'h308, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 32'h308,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b1, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 32'h308,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 3'b010, 1'b0, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h308,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h308,  32'h0,   3'b000, 3'b010, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  1'b0, 32'h308,  32'h0,   3'b010, 3'b010, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 1'b1, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h308,  32'h0,   3'b010, 3'b010, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1020, 32'h400, 3'b010, 3'b010, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h400,  32'h400, 3'b010, 3'b010, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h1020, 32'h500, 3'b010, 3'b000, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h504, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 32'h500,  32'h500, 3'b010, 3'b000, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 32'h508, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h508,  32'h500, 3'b010, 3'b000, 2'd2, 1'b0});

    foreach (tbl[i]) begin
      run_vec(i, tbl[i]);
    end

    // Request arriving while stalled is latched, and taken once STALL drops.
    run_vec(100, '{1'b1, 3'b000, 1'b0, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h600,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    run_vec(101, '{1'b0, 3'b000, 1'b0, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 32'h600,  32'h0,   3'b100, 3'b000, 2'd0, 1'b0});
    run_vec(102, '{1'b0, 3'b100, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h600,  32'h0,   3'b100, 3'b100, 2'd0, 1'b0});
    run_vec(103, '{1'b0, 3'b100, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h600,  32'h0,   3'b100, 3'b100, 2'd0, 1'b0});
    run_vec(104, '{1'b0, 3'b100, 1'b0, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1030, 32'h600, 3'b100, 3'b000, 2'd3, 1'b1});
    run_vec(105, '{1'b0, 3'b100, 1'b0, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h604,  32'h600, 3'b100, 3'b000, 2'd3, 1'b1});

`ifdef IRQ_NEST_EN
    // IRQ0 preempts an IRQ2 handler; two urets unwind back to 0x300.
    run_vec(200, '{1'b1, 3'b000, 1'b0, 32'h2fc, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h2fc,  32'h0,   3'b000, 3'b000, 2'd0, 1'b0});
    run_vec(201, '{1'b0, 3'b100, 1'b0, 32'h2fc, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 32'h2fc,  32'h0,   3'b111, 3'b100, 2'd0, 1'b0});
    run_vec(202, '{1'b0, 3'b100, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1030, 32'h300, 3'b111, 3'b000, 2'd3, 1'b1});
    run_vec(203, '{1'b0, 3'b101, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h400,  32'h300, 3'b111, 3'b001, 2'd3, 1'b1});
    run_vec(204, '{1'b0, 3'b101, 1'b0, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1010, 32'h404, 3'b111, 3'b000, 2'd1, 1'b1});
    run_vec(205, '{1'b0, 3'b101, 1'b0, 32'h408, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h404,  32'h300, 3'b111, 3'b000, 2'd3, 1'b1});
    run_vec(206, '{1'b0, 3'b101, 1'b0, 32'h40c, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h300,  32'h300, 3'b111, 3'b000, 2'd3, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
